// File: rtl/mips_cpu_pc_sequencer.sv
// Program counter sequencer: owns the PC and the branch-delay slot, and generates link writes and halt.
// PC updates one cycle after a retiring advance; taken transfers take effect after the delay slot retires.
// Backpressure: every update is gated by advance, and HALT ignores advance.
module mips_cpu_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_index,
  input  logic [4:0]  rd_index,
  input  logic [15:0] immediate,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_content,
  input  logic        sig_branch,
  output logic [31:0] pc,
  output logic        active,
  output logic        in_delay_slot,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        addr_error
);

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;

  logic        is_regimm;
  logic        regimm_br;
  logic        is_branch;
  logic        is_j;
  logic        is_jal;
  logic        is_jr;
  logic        is_jalr;
  logic        is_reg_jump;
  logic        taken;
  logic        misaligned;
  logic        wants_link;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] reg_target;
  logic [31:0] xfer_target;

  // Instruction decode for control transfers
  assign is_regimm   = (opcode == OP_REGIMM);
  assign regimm_br   = (rt_index == 5'd0) || (rt_index == 5'd1) ||
                       (rt_index == 5'd16) || (rt_index == 5'd17);
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                       (opcode == OP_BLEZ) || (opcode == OP_BGTZ) ||
                       (is_regimm && regimm_br);
  assign is_j        = (opcode == OP_J);
  assign is_jal      = (opcode == OP_JAL);
  assign is_jr       = (opcode == OP_SPECIAL) && (funct == FN_JR);
  assign is_jalr     = (opcode == OP_SPECIAL) && (funct == FN_JALR);
  assign is_reg_jump = is_jr || is_jalr;
  assign taken       = is_branch ? sig_branch : (is_j || is_jal || is_reg_jump);
  assign misaligned  = is_reg_jump && (rs_content[1:0] != 2'b00);
  // Link is an ISA property of the opcode, independent of whether the branch is taken
  assign wants_link  = is_jal || is_jalr || (is_regimm && rt_index[4]);

  // Target computation; all adds wrap mod 2^32
  assign pc_plus4      = pc + 32'd4;
  assign br_offset     = {{14{immediate[15]}}, immediate, 2'b00};
  assign branch_target = pc_plus4 + br_offset;
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign reg_target    = misaligned ? HALT_ADDR : rs_content;

  always_comb begin
    xfer_target = reg_target;
    if (is_branch) begin
      xfer_target = branch_target;
    end else if (is_j || is_jal) begin
      xfer_target = jump_target;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a transfer decoded in the delay slot is deliberately ignored
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (advance && taken) begin
          state_nxt = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (advance) begin
          state_nxt = (target == HALT_ADDR) ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Datapath registers: PC, pending target, sticky alignment error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_VECTOR;
      target     <= 32'd0;
      addr_error <= 1'b0;
    end else if (advance) begin
      case (state)
        ST_RUN: begin
          pc <= pc_plus4;
          if (taken) begin
            target <= xfer_target;
          end
          if (misaligned) begin
            addr_error <= 1'b1;
          end
        end
        ST_DELAY: begin
          pc <= target;
        end
        default: begin
          pc <= pc;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    active        = (state != ST_HALT);
    in_delay_slot = (state == ST_DELAY);
    link_we       = advance && (state == ST_RUN) && wants_link;
    link_reg      = is_jalr ? rd_index : 5'd31;
    link_addr     = pc + 32'd8;
  end

endmodule
